// File: rtl/serial_cmd_ctrl.sv
// serial_cmd_ctrl: parses SYNC/CMD/ADDR/[DATA] frames from the UART, drives a register bus
// and answers with ACK/NAK/read-data bytes over the TX handshake.
module serial_cmd_ctrl #(
  parameter int          TIMEOUT_CLKS = 100000,
  parameter int          RD_WAIT_CLKS = 255,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE     = 8'h4B,
  parameter logic [7:0]  NAK_BYTE     = 8'h4E
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Rx_DV,
  output logic       o_Tx_Start,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic [7:0] o_Reg_Addr,
  output logic [7:0] o_Reg_Wdata,
  output logic       o_Reg_We,
  output logic       o_Reg_Re,
  input  logic [7:0] i_Reg_Rdata,
  input  logic       i_Reg_Ack,
  output logic       o_Busy,
  output logic [7:0] o_Err_Count
);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam int RW = $clog2(RD_WAIT_CLKS + 1);
  typedef enum logic [3:0] {IDLE, GET_CMD, GET_ADDR, GET_DATA, REG_WR, REG_RD, WAIT_RD, TX_LOAD, TX_WAIT} state_t;
  state_t state;
  logic [16:0] ibt;
  logic [RW-1:0] rd_tmr;
  logic is_wr;
  logic [1:0][7:0] rsp;
  logic [1:0] cnt;
  logic ibt_exp;
  assign ibt_exp = ibt == 17'(TIMEOUT_CLKS - 1);
  assign o_Busy = state != IDLE;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
  // rd_tmr counts clocks since the Re strobe; ibt counts clocks since the last accepted frame byte
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      state       <= IDLE;
      ibt         <= '0;
      rd_tmr      <= '0;
      is_wr       <= 1'b0;
      rsp         <= '0;
      cnt         <= '0;
      o_Tx_Start  <= 1'b0;
      o_Tx_Byte   <= '0;
      o_Reg_Addr  <= '0;
      o_Reg_Wdata <= '0;
      o_Reg_We    <= 1'b0;
      o_Reg_Re    <= 1'b0;
      o_Err_Count <= '0;
    end else begin
      o_Tx_Start <= 1'b0;
      o_Reg_We   <= 1'b0;
      o_Reg_Re   <= 1'b0;
      ibt        <= ibt + 17'd1;
      case (state)
        IDLE:
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
            state <= GET_CMD;
            ibt   <= '0;
          end
        GET_CMD:
          if (i_Rx_DV) begin
            ibt <= '0;
            if (i_Rx_Byte == CMD_W || i_Rx_Byte == CMD_R) begin
              is_wr <= i_Rx_Byte == CMD_W;
              state <= GET_ADDR;
            end else begin
              rsp         <= {8'h00, NAK_BYTE};
              cnt         <= 2'd1;
              o_Err_Count <= sat_inc(o_Err_Count);
              state       <= TX_LOAD;
            end
          end else if (ibt_exp) begin
            o_Err_Count <= sat_inc(o_Err_Count);
            state       <= IDLE;
          end
        GET_ADDR:
          if (i_Rx_DV) begin
            ibt        <= '0;
            o_Reg_Addr <= i_Rx_Byte;
            rd_tmr     <= '0;
            o_Reg_Re   <= !is_wr;
            state      <= is_wr ? GET_DATA : REG_RD;
          end else if (ibt_exp) begin
            o_Err_Count <= sat_inc(o_Err_Count);
            state       <= IDLE;
          end
        GET_DATA:
          if (i_Rx_DV) begin
            ibt         <= '0;
            o_Reg_Wdata <= i_Rx_Byte;
            o_Reg_We    <= 1'b1;
            state       <= REG_WR;
          end else if (ibt_exp) begin
            o_Err_Count <= sat_inc(o_Err_Count);
            state       <= IDLE;
          end
        REG_WR: begin
          rsp   <= {8'h00, ACK_BYTE};
          cnt   <= 2'd1;
          state <= TX_LOAD;
        end
        REG_RD: begin
          rd_tmr <= rd_tmr + RW'(1);
          state  <= WAIT_RD;
        end
        WAIT_RD: begin
          rd_tmr <= rd_tmr + RW'(1);
          if (i_Reg_Ack) begin
            rsp   <= {i_Reg_Rdata, ACK_BYTE};
            cnt   <= 2'd2;
            state <= TX_LOAD;
          end else if (rd_tmr == RW'(RD_WAIT_CLKS - 1)) begin
            rsp         <= {8'h00, NAK_BYTE};
            cnt         <= 2'd1;
            o_Err_Count <= sat_inc(o_Err_Count);
            state       <= TX_LOAD;
          end
        end
        TX_LOAD:
          if (!i_Tx_Active) begin
            o_Tx_Byte  <= rsp[0];
            o_Tx_Start <= 1'b1;
            state      <= TX_WAIT;
          end
        TX_WAIT:
          if (i_Tx_Done) begin
            rsp   <= {8'h00, rsp[1]};
            cnt   <= cnt - 2'd1;
            state <= cnt == 2'd1 ? IDLE : TX_LOAD;
          end
        default: state <= IDLE;
      endcase
    end
  assert property (@(posedge i_Clock) disable iff (!i_Reset) !(o_Reg_We && o_Reg_Re));
  assert property (@(posedge i_Clock) disable iff (!i_Reset) o_Reg_We |-> state == REG_WR);
  assert property (@(posedge i_Clock) disable iff (!i_Reset) o_Reg_Re |-> state == REG_RD);
endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// tb_serial_cmd_ctrl: randomized frames against a frame-level reference model with a scoreboard
// monitor that checks register strobes and TX bytes as the DUT emits them.
module tb_serial_cmd_ctrl;
  localparam int TO = 300;
  localparam int RW = 255;
  logic clk = 0, rst_n = 0;
  logic [7:0] rx_byte = 0;
  logic rx_dv = 0;
  logic tx_start, tx_active = 0, tx_done = 0;
  logic [7:0] tx_byte;
  logic [7:0] reg_addr, reg_wdata, reg_rdata = 0;
  logic reg_we, reg_re, reg_ack = 0;
  logic busy;
  logic [7:0] err_count;
  int checks = 0, failures = 0, cyc = 0, err_m = 0;
  logic [7:0] exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic ack_en = 1;
  int ack_dly = 1, tx_len = 3, tx_extra = 0;
  logic [7:0] rd_val = 0, cur_tx = 0;
  int tx_cnt = 0, tx_ext = 0, ack_cnt = 0, re_cyc = 0, start_cyc = 0;

  always #5 clk = ~clk;

  serial_cmd_ctrl #(.TIMEOUT_CLKS(TO), .RD_WAIT_CLKS(RW)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_Rx_Byte(rx_byte), .i_Rx_DV(rx_dv),
    .o_Tx_Start(tx_start), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_Reg_Addr(reg_addr), .o_Reg_Wdata(reg_wdata), .o_Reg_We(reg_we), .o_Reg_Re(reg_re),
    .i_Reg_Rdata(reg_rdata), .i_Reg_Ack(reg_ack), .o_Busy(busy), .o_Err_Count(err_count)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Monitor, TX responder and register responder share one block so their ordering is fixed.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      tx_active = 0; tx_done = 0; reg_ack = 0; tx_cnt = 0; tx_ext = 0; ack_cnt = 0;
    end else begin
      if (reg_we) begin
        chk("we_re_exclusive", reg_re, 0);
        chk("we_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) chk("wr_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
      end
      if (reg_re) begin
        re_cyc = cyc;
        chk("re_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rd_addr", reg_addr, exp_rd.pop_front());
      end
      if (tx_start) begin
        start_cyc = cyc;
        chk("tx_idle_at_start", tx_active, 0);
        chk("tx_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_byte, exp_tx.pop_front());
        cur_tx = tx_byte;
      end
      tx_done = 0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          chk("tx_byte_hold", tx_byte, cur_tx);
          tx_done = 1; tx_ext = tx_extra; tx_active = tx_extra > 0;
        end
      end else if (tx_ext > 0) begin
        tx_ext--;
        if (tx_ext == 0) tx_active = 0;
      end
      if (tx_start) begin tx_active = 1; tx_cnt = tx_len; end
      reg_ack = 0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin reg_ack = 1; reg_rdata = rd_val; end
      end
      if (reg_re && ack_en) ack_cnt = ack_dly;
    end
  end

  task automatic send(logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_dv = 1;
    @(negedge clk); rx_dv = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_idle(string n);
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    chk(n, busy, 0);
    repeat (4) @(negedge clk);
  endtask

  function automatic void nak();
    exp_tx.push_back(8'h4E);
    err_m = err_m < 255 ? err_m + 1 : 255;
  endfunction

  task automatic do_write(logic [7:0] a, logic [7:0] d);
    exp_wr.push_back({a, d}); exp_tx.push_back(8'h4B);
    send(8'hA5); send(8'h57); send(a); send(d);
    wait_idle("write_idle");
    chk("write_err", err_count, err_m);
  endtask

  task automatic do_read(logic [7:0] a, logic [7:0] d, logic en, int dly);
    ack_en = en; ack_dly = dly; rd_val = d;
    exp_rd.push_back(a);
    if (en) begin exp_tx.push_back(8'h4B); exp_tx.push_back(d); end else nak();
    send(8'hA5); send(8'h52); send(a);
    wait_idle("read_idle");
    chk("read_err", err_count, err_m);
  endtask

  task automatic do_bad(logic [7:0] c);
    nak();
    send(8'hA5); send(c);
    wait_idle("bad_idle");
    chk("bad_err", err_count, err_m);
  endtask

  function automatic logic [7:0] bad_cmd();
    logic [7:0] c;
    do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
    return c;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {tx_start, tx_byte}, 0);
    chk("rst_reg", {reg_addr, reg_wdata, reg_we, reg_re}, 0);
    chk("rst_stat", {busy, err_count}, 0);
    rst_n = 1;
    @(negedge clk);
    do_write(8'h10, 8'h3C);
    do_read(8'h22, 8'h99, 1, 3);
    do_read(8'h22, 8'h00, 0, 0);
    chk("rd_nak_latency", start_cyc - re_cyc, RW + 1);
    chk("rd_nak_err", err_count, 1);
    do_bad(8'h33);
    do_write(8'h01, 8'hFF);
    do_read(8'h6E, 8'hC3, 1, RW - 1);
    // an A5 arriving while the read is outstanding must be ignored
    ack_en = 1; ack_dly = 8; rd_val = 8'h5A;
    exp_rd.push_back(8'h44); exp_tx.push_back(8'h4B); exp_tx.push_back(8'h5A);
    send(8'hA5); send(8'h52); send(8'h44); send(8'hA5);
    wait_idle("drop_idle");
    chk("drop_err", err_count, err_m);
    send(8'hA5); send(8'h57);
    repeat (TO - 20) @(negedge clk);
    chk("timeout_not_early", busy, 1);
    wait_idle("timeout_idle");
    err_m++;
    chk("timeout_err", err_count, err_m);
    send(8'h10);
    chk("stray_ignored", busy, 0);
    for (int i = 0; i < 40; i++) begin
      tx_len = $urandom_range(1, 6); tx_extra = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), 8'($urandom), 1, $urandom_range(1, 30));
        2: do_bad(bad_cmd());
        default: begin
          send(8'($urandom_range(0, 8'hA4)));
          do_write(8'($urandom), 8'($urandom));
        end
      endcase
    end
    tx_len = 20; tx_extra = 0;
    exp_wr.push_back(16'h7788); exp_tx.push_back(8'h4B);
    send(8'hA5); send(8'h57); send(8'h77); send(8'h88);
    for (int k = 0; k < 50 && !tx_active; k++) @(negedge clk);
    chk("tx_started", tx_active, 1);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("async_rst_tx", {tx_start, tx_byte}, 0);
    chk("async_rst_reg", {reg_addr, reg_wdata, reg_we, reg_re}, 0);
    chk("async_rst_stat", {busy, err_count}, 0);
    exp_tx.delete(); err_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    tx_len = 1;
    for (int i = 0; i < 256; i++) do_bad(bad_cmd());
    chk("err_saturated", err_count, 8'hFF);
    chk("sb_drain", exp_tx.size() + exp_wr.size() + exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
